// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and the helper that sizes the shift counter from the register width.
package shift_register_pkg;

    typedef enum logic [1:0] {
        SHREG_HOLD = 2'b00,
        SHREG_SHL  = 2'b01,
        SHREG_SHR  = 2'b10,
        SHREG_LOAD = 2'b11
    } shreg_mode_e;

    // Counter width able to hold 0..width-1; never narrower than one bit.
    function automatic int shreg_cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/shift_register_word_counter.sv
// Word framing counter: counts enabled shifts modulo WIDTH and pulses
// word_done for one cycle after the shift that completes a word.
module shift_register_word_counter
    import shift_register_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = shreg_cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clear,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] bit_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             word_done_d;
    logic             word_done_q;

    // Next count and pulse; a load clears the count, the pulse drops whenever no wrap occurs.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        word_done_d = 1'b0;
        if (clear) begin
            bit_cnt_d = CNT_ZERO;
        end else if (shift_en) begin
            if (bit_cnt_q == CNT_LAST) begin
                bit_cnt_d   = CNT_ZERO;
                word_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Counter and pulse flops; the pulse register updates every cycle so it never stretches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= CNT_ZERO;
            word_done_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign bit_cnt   = bit_cnt_q;
    assign word_done = word_done_q;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register (SISO/SIPO/PISO/PIPO) with word framing counter.
// Optional rotate support is enabled by defining SHIFT_REGISTER_ROTATE_EN,
// which adds the rot input that recirculates the exiting bit.
module shift_register_universal
    import shift_register_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = shreg_cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clken,
    input  logic [1:0]       mode,
`ifdef SHIFT_REGISTER_ROTATE_EN
    input  logic             rot,
`endif
    input  logic             si,
    input  logic [WIDTH-1:0] pdin,
    output logic             so,
    output logic [WIDTH-1:0] pdout,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done
);

    shreg_mode_e      mode_s;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] shreg_q;
    logic             fill_shl_s;
    logic             fill_shr_s;
    logic             shift_en_s;
    logic             clear_s;

    assign mode_s = shreg_mode_e'(mode);

`ifdef SHIFT_REGISTER_ROTATE_EN
    assign fill_shl_s = rot ? shreg_q[WIDTH-1] : si;
    assign fill_shr_s = rot ? shreg_q[0]       : si;
`else
    assign fill_shl_s = si;
    assign fill_shr_s = si;
`endif

    // Next register contents and counter controls, decoded from mode when enabled.
    always_comb begin
        shreg_d    = shreg_q;
        shift_en_s = 1'b0;
        clear_s    = 1'b0;
        if (clken) begin
            case (mode_s)
                SHREG_HOLD: begin
                    shreg_d = shreg_q;
                end
                SHREG_SHL: begin
                    shreg_d    = {shreg_q[WIDTH-2:0], fill_shl_s};
                    shift_en_s = 1'b1;
                end
                SHREG_SHR: begin
                    shreg_d    = {fill_shr_s, shreg_q[WIDTH-1:1]};
                    shift_en_s = 1'b1;
                end
                SHREG_LOAD: begin
                    shreg_d = pdin;
                    clear_s = 1'b1;
                end
                default: begin
                    shreg_d = shreg_q;
                end
            endcase
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= {WIDTH{1'b0}};
        end else begin
            shreg_q <= shreg_d;
        end
    end

    shift_register_word_counter #(
        .WIDTH (WIDTH)
    ) u_word_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (shift_en_s),
        .clear     (clear_s),
        .bit_cnt   (bit_cnt),
        .word_done (word_done)
    );

    // so shows the bit the next shift in the selected direction drops.
    assign so    = (mode_s == SHREG_SHR) ? shreg_q[0] : shreg_q[WIDTH-1];
    assign pdout = shreg_q;

endmodule
